register_file_param: RTL
========================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL take these parameters, one per line:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- N_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1 then register 0 reads as zero and ignores writes and reserves.

REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  single clock; all state changes on the rising edge.
- clr  in  1  reset; synchronous and active-high.
- write  in  1  write enable for write_reg.
- write_reg  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- read_reg  in  N_READ x ADDR_W  read addresses.
- read_data  out  N_READ x DATA_W  registered read data.
- read_busy  out  N_READ  registered busy flag of each addressed register.
- reserve  in  1  mark reserve_reg as having a pending producer.
- reserve_reg  in  ADDR_W  address to reserve.
- busy_count  out  ADDR_W+1  number of currently busy registers.

Function
REQ-003 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-004 A write with write=1 SHALL update write_reg with write_data at the next rising edge of clk.
REQ-005 Reads SHALL have 1-cycle latency: read_data[p] in cycle n+1 reflects read_reg[p] sampled in cycle n.
REQ-006 If write=1 and write_reg equals read_reg[p] in the same cycle, read_data[p] SHALL return write_data (write-first bypass).
REQ-007 With ZERO_REG=1, register 0 SHALL read as 0 regardless of bypass, and writes and reserves to it SHALL be ignored.
REQ-008 Each register SHALL have a busy bit: reserve=1 sets it and write=1 clears it, both effective at the next edge.
REQ-009 If reserve and write target the same register in the same cycle, the busy bit SHALL remain or become set (reserve wins).
REQ-010 Reserving an already-busy register SHALL leave it busy and SHALL NOT change busy_count.
REQ-011 A write to a non-busy register SHALL leave its busy bit clear and busy_count unchanged.
REQ-012 read_busy[p] SHALL be registered and use the post-update busy state, consistent with REQ-006 and REQ-009.
- Examples: same-cycle write-only to the address gives 0.
- Same-cycle reserve gives 1.
REQ-013 busy_count SHALL be registered.
- It SHALL equal the population count of busy bits after each edge.
- In one cycle it changes by -1, 0 or +1 (simultaneous set on one register and clear on another gives 0).
REQ-014 busy_count SHALL never exceed 2**ADDR_W - ZERO_REG; no wrap-around is permitted.
REQ-015 Multiple read ports addressing the same register SHALL return identical data and busy values.

Reset
REQ-016 While clr=1 at an edge, every register, busy bit, read_data, read_busy and busy_count SHALL become 0.
REQ-017 Writes and reserves presented in a cycle with clr=1 SHALL be discarded (reset has priority).
REQ-018 In the first cycle after clr deasserts, normal operation SHALL resume with no extra latency.

Structure
REQ-019 A shared package rf_pkg SHALL hold:
- the default DATA_W, ADDR_W and N_READ constants;
- the data and address typedefs derived from them.
REQ-020 The busy-bit array and busy_count logic SHALL be a sub-module named rf_scoreboard, instantiated once.

Verification
REQ-021 Reset: drive clr=1 for 1 cycle after random writes -> every read returns 0x00000000, read_busy=0, busy_count=0.
REQ-022 Write/read: write 0xDEADBEEF to r5, then read r5 on port 1 the next cycle -> read_data[1]=0xDEADBEEF one cycle later.
REQ-023 Bypass and zero register, checked separately:
- Write r7=0x12345678 while both ports read r7 -> both return 0x12345678 next cycle.
- Write r0=0xFFFFFFFF -> r0 reads 0.
REQ-024 Scoreboard:
- Reserve r3, then r4 -> busy_count=2.
- Then write r3 and reserve r9 in the same cycle -> busy_count=2, with r3 clear and r9 busy.
- Then reserve r9 again -> busy_count=2.
REQ-025 Conflict: reserve r12 and write r12=0xA5A5A5A5 in the same cycle -> read r12 gives 0xA5A5A5A5 with read_busy=1.
REQ-026 Saturation and mid-operation reset:
- Reserve r1..r31 -> busy_count=31.
- Assert clr together with a write -> busy_count=0 and the write is discarded.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the parameterised register file.
// Defaults describe a 32 x 32-bit file with two read ports.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_N_READ = 2;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with registered per-port busy flags and a running busy count.
// Busy flags reflect the state after this cycle's reserve/write, so reads see same-cycle updates.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_READ   = RF_N_READ,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           write,
  input  logic [ADDR_W-1:0]              write_reg,
  input  logic                           reserve,
  input  logic [ADDR_W-1:0]              reserve_reg,
  input  logic [N_READ-1:0][ADDR_W-1:0]  read_reg,
  output logic [N_READ-1:0]              read_busy,
  output logic [ADDR_W:0]                busy_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   busy_count_reg;
  logic [ADDR_W:0]   busy_count_next;
  logic              write_eff;
  logic              reserve_eff;
  logic              count_inc;
  logic              count_dec;

  assign write_eff   = write && !((ZERO_REG != 0) && (write_reg == '0));
  assign reserve_eff = reserve && !((ZERO_REG != 0) && (reserve_reg == '0));

  // Reserve wins over a same-cycle write to the same register.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign busy_next[gi] = (reserve_eff && (reserve_reg == ADDR_W'(gi))) ||
                             (busy_reg[gi] && !(write_eff && (write_reg == ADDR_W'(gi))));
    end
  endgenerate

  // Count moves only on real 0->1 / 1->0 transitions, so it cannot overrun the depth.
  assign count_inc = reserve_eff && !busy_reg[reserve_reg];
  assign count_dec = write_eff && busy_reg[write_reg] &&
                     !(reserve_eff && (reserve_reg == write_reg));

  always_comb begin
    busy_count_next = busy_count_reg;
    if (count_inc && !count_dec) begin
      busy_count_next = busy_count_reg + (ADDR_W + 1)'(1);
    end else if (count_dec && !count_inc) begin
      busy_count_next = busy_count_reg - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      busy_reg       <= '0;
      busy_count_reg <= '0;
    end else begin
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
    end
  end

  generate
    for (gi = 0; gi < N_READ; gi++) begin : g_rd_busy
      logic read_busy_reg;
      always_ff @(posedge clk) begin
        if (clr) begin
          read_busy_reg <= 1'b0;
        end else begin
          read_busy_reg <= busy_next[read_reg[gi]];
        end
      end
      assign read_busy[gi] = read_busy_reg;
    end
  endgenerate

  assign busy_count = busy_count_reg;

endmodule

// File: rtl/register_file_param.sv
// Parameterised register file with write-first bypass, optional hard-wired zero register
// and a busy-bit scoreboard for tracking pending producers.
module register_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_READ   = RF_N_READ,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           write,
  input  logic [ADDR_W-1:0]              write_reg,
  input  logic [DATA_W-1:0]              write_data,
  input  logic [N_READ-1:0][ADDR_W-1:0]  read_reg,
  output logic [N_READ-1:0][DATA_W-1:0]  read_data,
  output logic [N_READ-1:0]              read_busy,
  input  logic                           reserve,
  input  logic [ADDR_W-1:0]              reserve_reg,
  output logic [ADDR_W:0]                busy_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              write_eff;

  assign write_eff = write && !((ZERO_REG != 0) && (write_reg == '0));

  // Storage is cleared on reset, so it maps to flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (write_eff) begin
      mem_reg[write_reg] <= write_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_READ; gi++) begin : g_read
      logic [DATA_W-1:0] data_next;
      logic [DATA_W-1:0] data_reg;

      // Zero register overrides the bypass path.
      always_comb begin
        data_next = mem_reg[read_reg[gi]];
        if (write_eff && (write_reg == read_reg[gi])) begin
          data_next = write_data;
        end
        if ((ZERO_REG != 0) && (read_reg[gi] == '0)) begin
          data_next = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          data_reg <= '0;
        end else begin
          data_reg <= data_next;
        end
      end

      assign read_data[gi] = data_reg;
    end
  endgenerate

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_READ   (N_READ),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .clr         (clr),
    .write       (write),
    .write_reg   (write_reg),
    .reserve     (reserve),
    .reserve_reg (reserve_reg),
    .read_reg    (read_reg),
    .read_busy   (read_busy),
    .busy_count  (busy_count)
  );

endmodule
